// File: rtl/piso_stream.sv
// piso_stream: parallel-in / serial-out serializer with valid/ready on both
// sides. A one-entry holding buffer (hb) sits in front of the shifter so the
// next word can be taken while the current one shifts, giving gap-free
// streaming. Direction (LSB/MSB first) is captured with each word.
module piso_stream #(
  parameter  int DATA_WIDTH = 8,
  localparam int CNT_W      = $clog2(DATA_WIDTH + 1)
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  abort,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_msb_first,
  output logic                  sout_valid,
  input  logic                  sout_ready,
  output logic                  sout,
  output logic                  sout_last,
  output logic                  busy
);

  logic [DATA_WIDTH-1:0] sr_q, sr_d;
  logic                  dir_q, dir_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] hb_q, hb_d;
  logic                  hb_dir_q, hb_dir_d;
  logic                  hb_full_q, hb_full_d;

  logic active;
  logic accept;
  logic xfer;
  logic shifter_free;

  // Handshake decode and registered-only outputs (no ready->valid paths)
  always_comb begin
    active       = (cnt_q != '0);
    accept       = in_valid & ~hb_full_q;
    xfer         = active & sout_ready;
    // Shifter can take a new word next cycle: idle now, or last bit leaving
    shifter_free = ~active | (xfer & (cnt_q == CNT_W'(1)));

    in_ready   = ~hb_full_q;
    sout_valid = active;
    sout       = active ? (dir_q ? sr_q[DATA_WIDTH-1] : sr_q[0]) : 1'b0;
    sout_last  = active & (cnt_q == CNT_W'(1));
    busy       = active | hb_full_q;
  end

  // Next-state: abort > reload from hb > direct load > shift / buffer
  always_comb begin
    sr_d      = sr_q;
    dir_d     = dir_q;
    cnt_d     = cnt_q;
    hb_d      = hb_q;
    hb_dir_d  = hb_dir_q;
    hb_full_d = hb_full_q;

    if (abort) begin
      cnt_d     = '0;
      hb_full_d = 1'b0;
    end else if (shifter_free) begin
      if (hb_full_q) begin
        sr_d      = hb_q;
        dir_d     = hb_dir_q;
        cnt_d     = CNT_W'(DATA_WIDTH);
        hb_full_d = accept;
        if (accept) begin
          hb_d     = in_data;
          hb_dir_d = in_msb_first;
        end
      end else if (accept) begin
        sr_d  = in_data;
        dir_d = in_msb_first;
        cnt_d = CNT_W'(DATA_WIDTH);
      end else begin
        cnt_d = '0;
      end
    end else begin
      if (xfer) begin
        sr_d  = dir_q ? {sr_q[DATA_WIDTH-2:0], 1'b0} : {1'b0, sr_q[DATA_WIDTH-1:1]};
        cnt_d = cnt_q - CNT_W'(1);
      end
      if (accept) begin
        hb_d      = in_data;
        hb_dir_d  = in_msb_first;
        hb_full_d = 1'b1;
      end
    end
  end

  // State registers, cleared asynchronously so outputs drop without a clock
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sr_q      <= '0;
      dir_q     <= 1'b0;
      cnt_q     <= '0;
      hb_q      <= '0;
      hb_dir_q  <= 1'b0;
      hb_full_q <= 1'b0;
    end else begin
      sr_q      <= sr_d;
      dir_q     <= dir_d;
      cnt_q     <= cnt_d;
      hb_q      <= hb_d;
      hb_dir_q  <= hb_dir_d;
      hb_full_q <= hb_full_d;
    end
  end

endmodule

// File: tb/tb_piso_stream.sv
// Directed bench for piso_stream: inputs change and outputs are sampled on
// the falling clock edge, away from the rising edge where state updates.
module tb_piso_stream;

  logic       clk = 1'b0;
  logic       resetn;
  logic       abort;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       in_msb_first;
  logic       sout_valid;
  logic       sout_ready;
  logic       sout;
  logic       sout_last;
  logic       busy;

  int n_cmp = 0;
  int n_err = 0;

  piso_stream #(.DATA_WIDTH(8)) dut (
    .clk          (clk),
    .resetn       (resetn),
    .abort        (abort),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .in_msb_first (in_msb_first),
    .sout_valid   (sout_valid),
    .sout_ready   (sout_ready),
    .sout         (sout),
    .sout_last    (sout_last),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, ".valid"}, sout_valid, 1'b0);
    chk({tag, ".sout"},  sout,       1'b0);
    chk({tag, ".last"},  sout_last,  1'b0);
    chk({tag, ".busy"},  busy,       1'b0);
    chk({tag, ".ready"}, in_ready,   1'b1);
  endtask

  // Offer one word, then check all 8 bits with sout_ready held high
  task automatic run_word(input string tag, input logic [7:0] d, input logic msb);
    @(negedge clk);
    in_valid = 1'b1; in_data = d; in_msb_first = msb; sout_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      in_valid = 1'b0;
      chk($sformatf("%s.v%0d", tag, i), sout_valid, 1'b1);
      chk($sformatf("%s.b%0d", tag, i), sout, msb ? d[7-i] : d[i]);
      chk($sformatf("%s.l%0d", tag, i), sout_last, (i == 7));
    end
    @(negedge clk);
    chk_idle({tag, ".end"});
  endtask

  logic [7:0] words [3];
  logic       dirs  [3];
  logic       acc;
  int         idx;
  int         bit_i;
  logic [7:0] exp_w [2];
  logic       exp_d [2];

  initial begin
    resetn = 1'b0; abort = 1'b0; in_valid = 1'b0; in_data = '0;
    in_msb_first = 1'b0; sout_ready = 1'b0;
    #12;
    chk_idle("rst");
    @(negedge clk);
    resetn = 1'b1;

    // Single words in both directions
    run_word("lsb_a5", 8'hA5, 1'b0);
    run_word("msb_a5", 8'hA5, 1'b1);
    run_word("msb_01", 8'h01, 1'b1);

    // Back-to-back stream: 24 bits without a gap
    words[0] = 8'hFF; dirs[0] = 1'b0;
    words[1] = 8'h00; dirs[1] = 1'b1;
    words[2] = 8'h81; dirs[2] = 1'b0;
    idx = 0;
    @(negedge clk);
    in_valid = 1'b1; in_data = words[0]; in_msb_first = dirs[0]; sout_ready = 1'b1;
    acc = in_valid & in_ready;
    for (int b = 0; b < 24; b++) begin
      @(negedge clk);
      if (acc) begin
        idx++;
        if (idx < 3) begin
          in_data = words[idx]; in_msb_first = dirs[idx];
        end else begin
          in_valid = 1'b0;
        end
      end
      chk($sformatf("b2b.v%0d", b), sout_valid, 1'b1);
      chk($sformatf("b2b.b%0d", b), sout,
          dirs[b/8] ? words[b/8][7-(b%8)] : words[b/8][b%8]);
      chk($sformatf("b2b.l%0d", b), sout_last, ((b % 8) == 7));
      if (b == 1) chk("b2b.in_ready_full", in_ready, 1'b0);
      acc = in_valid & in_ready;
    end
    @(negedge clk);
    in_valid = 1'b0;
    chk_idle("b2b.end");

    // Backpressure on 8'h3C with a second word 8'hC3 (MSB) taken during stall
    exp_w[0] = 8'h3C; exp_d[0] = 1'b0;
    exp_w[1] = 8'hC3; exp_d[1] = 1'b1;
    @(negedge clk);
    in_valid = 1'b1; in_data = 8'h3C; in_msb_first = 1'b0;
    bit_i = 0;
    for (int c = 0; c < 18; c++) begin
      @(negedge clk);
      sout_ready = !(c == 1 || c == 2);
      if (c == 1) begin
        in_valid = 1'b1; in_data = 8'hC3; in_msb_first = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      chk($sformatf("bp.v%0d", c), sout_valid, 1'b1);
      chk($sformatf("bp.b%0d", c), sout,
          exp_d[bit_i/8] ? exp_w[bit_i/8][7-(bit_i%8)] : exp_w[bit_i/8][bit_i%8]);
      chk($sformatf("bp.l%0d", c), sout_last, ((bit_i % 8) == 7));
      if (sout_ready) bit_i++;
    end
    @(negedge clk);
    sout_ready = 1'b1;
    chk_idle("bp.end");

    // Abort on bit 3 of 8'hF0 with 8'h0F buffered and a third word offered
    @(negedge clk);
    in_valid = 1'b1; in_data = 8'hF0; in_msb_first = 1'b0;
    @(negedge clk);
    in_data = 8'h0F;
    chk("ab.b0", sout, 1'b0);
    @(negedge clk);
    in_data = 8'h77;
    chk("ab.hb_full", in_ready, 1'b0);
    @(negedge clk);
    chk("ab.busy", busy, 1'b1);
    @(negedge clk);
    abort = 1'b1;
    chk("ab.v3", sout_valid, 1'b1);
    @(negedge clk);
    abort = 1'b0; in_valid = 1'b0;
    chk_idle("ab.next");
    @(negedge clk);
    chk_idle("ab.later");

    // Abort also discards an accept into an idle shifter
    abort = 1'b1; in_valid = 1'b1; in_data = 8'hAA;
    @(negedge clk);
    abort = 1'b0; in_valid = 1'b0;
    chk_idle("ab_idle");

    // Async reset during bit 5 of 8'hE7 (bit 5 = 1), then 8'h5A in full
    @(negedge clk);
    in_valid = 1'b1; in_data = 8'hE7; in_msb_first = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      in_valid = 1'b0;
    end
    chk("ar.pre_valid", sout_valid, 1'b1);
    chk("ar.pre_bit5",  sout,       1'b1);
    #2 resetn = 1'b0;
    #1;
    chk_idle("ar.async");
    @(negedge clk);
    resetn = 1'b1;
    chk_idle("ar.released");
    run_word("ar_5a", 8'h5A, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
